// File: rtl/rst_seq_if.sv
`default_nettype none
// ============================================================================
//  Module      : rst_seq_if
//  Description : Lock/request inputs and sequenced reset outputs of the
//                reset release sequencer.
//  Revision    : 1.0 - initial release
// ============================================================================
interface rst_seq_if #(
    parameter int NUM_RST = 4
);
    logic               lock_i;
    logic               sw_rst_req_i;
    logic [NUM_RST-1:0] rst_n_o;
    logic               done_o;
    logic               busy_o;

    // Side that supplies lock/request and observes the domain resets
    modport master (
        output lock_i,
        output sw_rst_req_i,
        input  rst_n_o,
        input  done_o,
        input  busy_o
    );

    // The sequencer itself
    modport slave (
        input  lock_i,
        input  sw_rst_req_i,
        output rst_n_o,
        output done_o,
        output busy_o
    );
endinterface
`default_nettype wire

// File: rtl/rst_seq.sv
`default_nettype none
// ============================================================================
//  Module      : rst_seq
//  Description : Reset release sequencer. Holds all domain resets for
//                HOLD_CYC clean cycles, then releases them one by one in index
//                order every STEP_DLY cycles. Loss of lock or a software
//                request re-asserts everything and restarts the sequence.
//  Revision    : 1.0 - initial release
// ============================================================================
module rst_seq #(
    parameter int NUM_RST  = 4,
    parameter int HOLD_CYC = 16,
    parameter int STEP_DLY = 8
) (
    input  wire      clk_i,
    input  wire      rst_n_i,
    rst_seq_if.slave bus
);

    localparam int c_MAX_DLY = (HOLD_CYC > STEP_DLY) ? HOLD_CYC : STEP_DLY;
    localparam int c_CNT_W   = $clog2(c_MAX_DLY + 1);
    localparam int c_IDX_W   = $clog2(NUM_RST + 1);

    localparam logic [c_CNT_W-1:0] c_HOLD_LAST = c_CNT_W'(HOLD_CYC - 1);
    localparam logic [c_CNT_W-1:0] c_STEP_LAST = c_CNT_W'(STEP_DLY - 1);
    localparam logic [c_IDX_W-1:0] c_IDX_LAST  = c_IDX_W'(NUM_RST - 1);

    localparam logic [1:0] c_ST_HOLD    = 2'd0;
    localparam logic [1:0] c_ST_RELEASE = 2'd1;
    localparam logic [1:0] c_ST_DONE    = 2'd2;

    logic [1:0]         r_state;
    logic [c_CNT_W-1:0] r_cnt;
    logic [c_IDX_W-1:0] r_idx;
    logic [NUM_RST-1:0] r_rst_n;
    logic               r_done;
    logic               r_busy;

    logic [1:0]         w_state_nxt;
    logic [c_CNT_W-1:0] w_cnt_nxt;
    logic [c_IDX_W-1:0] w_idx_nxt;
    logic [NUM_RST-1:0] w_rst_n_nxt;
    logic               w_done_nxt;
    logic [NUM_RST-1:0] w_idx_mask;

    // Re-assert has priority over everything, including a coincident release
    wire w_reassert = bus.sw_rst_req_i | ~bus.lock_i;
    wire w_hold_hit = (r_cnt == c_HOLD_LAST);
    wire w_step_hit = (r_cnt == c_STEP_LAST);
    wire w_last_idx = (r_idx == c_IDX_LAST);

    // State and registered outputs; async reset forces the fully-held state
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_state <= c_ST_HOLD;
            r_cnt   <= '0;
            r_idx   <= '0;
            r_rst_n <= '0;
            r_done  <= 1'b0;
            r_busy  <= 1'b1;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_idx   <= w_idx_nxt;
            r_rst_n <= w_rst_n_nxt;
            r_done  <= w_done_nxt;
            r_busy  <= ~w_done_nxt;
        end
    end

    // One-hot decode of the index of the next bit to release
    always_comb begin
        w_idx_mask = '0;
        for (int k = 0; k < NUM_RST; k++) begin
            if (r_idx == c_IDX_W'(k)) begin
                w_idx_mask[k] = 1'b1;
            end
        end
    end

    // Next-state selection
    always_comb begin
        w_state_nxt = r_state;
        if (w_reassert) begin
            w_state_nxt = c_ST_HOLD;
        end else begin
            case (r_state)
                c_ST_HOLD:    if (w_hold_hit) w_state_nxt = c_ST_RELEASE;
                c_ST_RELEASE: if (w_step_hit && w_last_idx) w_state_nxt = c_ST_DONE;
                c_ST_DONE:    w_state_nxt = c_ST_DONE;
                default:      w_state_nxt = c_ST_HOLD;
            endcase
        end
    end

    // Next values of counter, index and the registered outputs
    always_comb begin
        w_cnt_nxt   = r_cnt;
        w_idx_nxt   = r_idx;
        w_rst_n_nxt = r_rst_n;
        w_done_nxt  = r_done;
        if (w_reassert) begin
            w_cnt_nxt   = '0;
            w_idx_nxt   = '0;
            w_rst_n_nxt = '0;
            w_done_nxt  = 1'b0;
        end else begin
            case (r_state)
                c_ST_HOLD: begin
                    w_rst_n_nxt = '0;
                    w_done_nxt  = 1'b0;
                    w_idx_nxt   = '0;
                    w_cnt_nxt   = w_hold_hit ? '0 : r_cnt + c_CNT_W'(1);
                end
                c_ST_RELEASE: begin
                    if (w_step_hit) begin
                        w_cnt_nxt   = '0;
                        w_rst_n_nxt = r_rst_n | w_idx_mask;
                        w_idx_nxt   = w_last_idx ? '0 : r_idx + c_IDX_W'(1);
                        w_done_nxt  = w_last_idx;
                    end else begin
                        w_cnt_nxt = r_cnt + c_CNT_W'(1);
                    end
                end
                c_ST_DONE: begin
                    w_cnt_nxt   = '0;
                    w_idx_nxt   = '0;
                    w_rst_n_nxt = '1;
                    w_done_nxt  = 1'b1;
                end
                default: begin
                    w_cnt_nxt   = '0;
                    w_idx_nxt   = '0;
                    w_rst_n_nxt = '0;
                    w_done_nxt  = 1'b0;
                end
            endcase
        end
    end

    assign bus.rst_n_o = r_rst_n;
    assign bus.done_o  = r_done;
    assign bus.busy_o  = r_busy;

endmodule
`default_nettype wire
